// File: rtl/reconhecimento_pkg.sv
// Shared types and constants for the digit template-matching pipeline.
// Grid geometry, pixel/score widths and the accumulator state encoding.
package reconhecimento_pkg;

    localparam int N     = 11;
    localparam int W     = 8;
    localparam int SUM_W = 15;
    localparam int IDX_W = $clog2(N);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIM  = 2'd2
    } estado_t;

    typedef logic [W-1:0] pixel_array_t [N-1:0][N-1:0];

endpackage

// File: rtl/seletor_pixel.sv
// Combinational N*N:1 selector returning the snapshot pixel at (row, col).
// Out-of-range indices read as zero so the mux never indexes past the array.
module seletor_pixel
    import reconhecimento_pkg::*;
(
    input  logic [W-1:0]     pixels [N-1:0][N-1:0],
    input  logic [IDX_W-1:0] row,
    input  logic [IDX_W-1:0] col,
    output logic [W-1:0]     pixel
);

    always_comb begin
        pixel = '0;
        if ((row <= MAX_IDX) && (col <= MAX_IDX)) begin
            pixel = pixels[row][col];
        end
    end

endmodule

// File: rtl/soma_diferenca.sv
// Serial raster-order sum of an N x N difference snapshot, one pixel per clock.
// The total is the match score for one digit; lower is better, with optional early abort.
module soma_diferenca
    import reconhecimento_pkg::*;
#(
    parameter logic [SUM_W-1:0] LIMIT = SUM_W'(32767)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     diff_pixel [N-1:0][N-1:0],
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] soma,
    output logic             excedeu
);

    estado_t            state_reg, state_next;
    pixel_array_t       snap_reg;
    logic [SUM_W-1:0]   acc_reg, acc_next;
    logic [IDX_W-1:0]   row_reg, col_reg;
    logic [SUM_W-1:0]   soma_reg;
    logic               excedeu_reg;
    logic [W-1:0]       pixel_atual;
    logic               capture, ultimo, acima, fim_acc;

    seletor_pixel u_seletor (
        .pixels (snap_reg),
        .row    (row_reg),
        .col    (col_reg),
        .pixel  (pixel_atual)
    );

    // start only matters outside ACC; a request during accumulation is dropped.
    assign capture  = start && (state_reg != ACC);
    assign acc_next = acc_reg + SUM_W'(pixel_atual);
    assign ultimo   = (row_reg == MAX_IDX) && (col_reg == MAX_IDX);
    assign acima    = acc_next > LIMIT;
    assign fim_acc  = ultimo || acima;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ACC;
            ACC:     if (fim_acc) state_next = FIM;
            FIM:     state_next = start ? ACC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == ACC);
        done = (state_reg == FIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    snap_reg[i][j] <= '0;
                end
            end
        end else if (capture) begin
            snap_reg <= diff_pixel;
        end
    end

    // soma/excedeu change only when a sum completes, so partial sums never leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            soma_reg    <= '0;
            excedeu_reg <= 1'b0;
        end else if (capture) begin
            acc_reg     <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            excedeu_reg <= 1'b0;
        end else if (state_reg == ACC) begin
            acc_reg <= acc_next;
            if (col_reg == MAX_IDX) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
            if (fim_acc) begin
                soma_reg    <= acc_next;
                excedeu_reg <= acima;
            end
        end
    end

    assign soma    = soma_reg;
    assign excedeu = excedeu_reg;

endmodule

// File: tb/tb_soma_diferenca.sv
// Randomised self-checking bench: default-LIMIT instance plus a LIMIT=1000 instance,
// both fed the same stimulus and checked against a plain-arithmetic reference sum.
module tb_soma_diferenca;

    localparam int NN   = 11;
    localparam int SW   = 15;
    localparam int LIM_B = 1000;

    typedef logic [7:0] img_t [NN-1:0][NN-1:0];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    img_t          img;
    logic          busy_a, done_a, exc_a, busy_b, done_b, exc_b;
    logic [SW-1:0] soma_a, soma_b;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    soma_diferenca dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .diff_pixel(img),
        .busy(busy_a), .done(done_a), .soma(soma_a), .excedeu(exc_a)
    );

    soma_diferenca #(.LIMIT(15'd1000)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .diff_pixel(img),
        .busy(busy_b), .done(done_b), .soma(soma_b), .excedeu(exc_b)
    );

    // Reference: raster-order running sum, stopping at the first pixel that pushes it past limit.
    function automatic void ref_sum(input img_t p, input int limit,
                                    output int s, output bit exc, output int lat);
        s = 0; exc = 0; lat = NN * NN;
        for (int k = 0; k < NN * NN; k++) begin
            s += int'(p[k / NN][k % NN]);
            if (s > limit) begin
                exc = 1; lat = k + 1;
                return;
            end
        end
    endfunction

    task automatic fill_const(input int v);
        for (int i = 0; i < NN; i++)
            for (int j = 0; j < NN; j++)
                img[i][j] = 8'(v);
    endtask

    task automatic fill_rand(input int maxv);
        for (int i = 0; i < NN; i++)
            for (int j = 0; j < NN; j++)
                img[i][j] = 8'($urandom_range(0, maxv));
    endtask

    // Leaves the bench 1 time unit after the capturing edge, start already low.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called 1 time unit after the capturing edge; returns when dut_a's done is seen.
    task automatic run_until_done(input int pulse_at,
                                  output int lat_a, output int lat_b, output int busy_cnt,
                                  output logic [SW-1:0] sa, output logic ea,
                                  output logic [SW-1:0] sb, output logic eb);
        int cyc = 0;
        bit got_a = 0, got_b = 0;
        lat_a = -1; lat_b = -1; sa = '0; ea = 1'b0; sb = '0; eb = 1'b0;
        busy_cnt = busy_a ? 1 : 0;
        while (!got_a && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == pulse_at);
            if (done_b && !got_b) begin
                got_b = 1; lat_b = cyc; sb = soma_b; eb = exc_b;
            end
            if (done_a) begin
                got_a = 1; lat_a = cyc; sa = soma_a; ea = exc_a;
            end else if (busy_a) begin
                busy_cnt++;
            end
        end
        start = 1'b0;
        if (!got_a) begin
            mismatched++;
            $display("FAIL timeout: no done within 300 cycles (got %0d, required 1)", got_a);
        end
    endtask

    task automatic test_reset();
        compared++;
        if ({busy_a, done_a, soma_a, exc_a} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: busy=%b done=%b soma=%0d excedeu=%b, required all 0",
                     busy_a, done_a, soma_a, exc_a);
        end
        $display("reset: busy=%b done=%b soma=%0d excedeu=%b", busy_a, done_a, soma_a, exc_a);
    endtask

    task automatic test_zero();
        int la, lb, bc;
        logic [SW-1:0] sa, sb;
        logic ea, eb;
        fill_const(0);
        do_start();
        run_until_done(-1, la, lb, bc, sa, ea, sb, eb);
        compared++;
        if (la != 121 || sa !== '0 || ea !== 1'b0 || bc != 121) begin
            mismatched++;
            $display("FAIL zero_sum: lat=%0d soma=%0d exc=%b busy_cycles=%0d, required 121/0/0/121",
                     la, sa, ea, bc);
        end
        @(posedge clk);
        #1;
        compared++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            mismatched++;
            $display("FAIL done_one_cycle: done=%b busy=%b after FIM, required 0/0", done_a, busy_a);
        end
        $display("zero: lat=%0d soma=%0d exc=%b busy_cycles=%0d", la, sa, ea, bc);
    endtask

    task automatic test_all_max();
        int la, lb, bc, es, el;
        bit ee;
        logic [SW-1:0] sa, sb;
        logic ea, eb;
        fill_const(255);
        ref_sum(img, 32767, es, ee, el);
        do_start();
        run_until_done(-1, la, lb, bc, sa, ea, sb, eb);
        compared++;
        if (sa !== SW'(es) || ea !== ee || la != el) begin
            mismatched++;
            $display("FAIL all_max: soma=%0d exc=%b lat=%0d, required %0d/%b/%0d", sa, ea, la, es, ee, el);
        end
        $display("all_max: soma=%0d exc=%b lat=%0d (expected %0d)", sa, ea, la, es);
    endtask

    task automatic test_back_to_back();
        int la, lb, bc;
        logic [SW-1:0] sa, sb;
        logic ea, eb;
        fill_const(0);
        img[10][10] = 8'd200;
        do_start();
        run_until_done(-1, la, lb, bc, sa, ea, sb, eb);
        compared++;
        if (sa !== SW'(200) || la != 121) begin
            mismatched++;
            $display("FAIL b2b_first: soma=%0d lat=%0d, required 200/121", sa, la);
        end
        // Still in the FIM cycle: restart with no gap.
        fill_const(0);
        img[0][0] = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        compared++;
        if (busy_a !== 1'b1 || done_a !== 1'b0 || soma_a !== SW'(200)) begin
            mismatched++;
            $display("FAIL b2b_restart: busy=%b done=%b soma=%0d, required 1/0/200", busy_a, done_a, soma_a);
        end
        run_until_done(-1, la, lb, bc, sa, ea, sb, eb);
        compared++;
        if (sa !== SW'(7) || la != 121 || ea !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_second: soma=%0d lat=%0d exc=%b, required 7/121/0", sa, la, ea);
        end
        $display("back_to_back: second soma=%0d lat=%0d", sa, la);
    endtask

    task automatic test_abort();
        int la, lb, bc;
        logic [SW-1:0] sa, sb;
        logic ea, eb;
        fill_const(100);
        do_start();
        run_until_done(-1, la, lb, bc, sa, ea, sb, eb);
        compared++;
        if (lb != 11 || sb !== SW'(1100) || eb !== 1'b1) begin
            mismatched++;
            $display("FAIL abort: lat=%0d soma=%0d exc=%b, required 11/1100/1", lb, sb, eb);
        end
        compared++;
        if (sa !== SW'(12100) || ea !== 1'b0 || la != 121) begin
            mismatched++;
            $display("FAIL no_abort_default: soma=%0d exc=%b lat=%0d, required 12100/0/121", sa, ea, la);
        end
        $display("abort: limited lat=%0d soma=%0d exc=%b; default soma=%0d", lb, sb, eb, sa);
    endtask

    task automatic test_snapshot();
        int la, lb, bc, extra;
        logic [SW-1:0] sa, sb;
        logic ea, eb;
        fill_const(1);
        do_start();
        fill_const(255);
        run_until_done(60, la, lb, bc, sa, ea, sb, eb);
        compared++;
        if (sa !== SW'(121) || la != 121 || ea !== 1'b0) begin
            mismatched++;
            $display("FAIL snapshot: soma=%0d lat=%0d exc=%b, required 121/121/0", sa, la, ea);
        end
        extra = 0;
        repeat (130) begin
            @(posedge clk);
            #1;
            if (done_a) extra++;
        end
        compared++;
        if (extra != 0) begin
            mismatched++;
            $display("FAIL ignored_start: %0d extra done pulses, required 0", extra);
        end
        $display("snapshot: soma=%0d lat=%0d extra_done=%0d", sa, la, extra);
    endtask

    task automatic test_random();
        int la, lb, bc, esa, ela, esb, elb;
        bit eea, eeb;
        logic [SW-1:0] sa, sb;
        logic ea, eb;
        for (int r = 0; r < 6; r++) begin
            fill_rand((r % 2 == 0) ? 15 : 255);
            ref_sum(img, 32767, esa, eea, ela);
            ref_sum(img, LIM_B, esb, eeb, elb);
            do_start();
            run_until_done(-1, la, lb, bc, sa, ea, sb, eb);
            compared++;
            if (sa !== SW'(esa) || ea !== eea || la != ela) begin
                mismatched++;
                $display("FAIL rand_default[%0d]: soma=%0d exc=%b lat=%0d, required %0d/%b/%0d",
                         r, sa, ea, la, esa, eea, ela);
            end
            compared++;
            if (sb !== SW'(esb) || eb !== eeb || lb != elb) begin
                mismatched++;
                $display("FAIL rand_limit[%0d]: soma=%0d exc=%b lat=%0d, required %0d/%b/%0d",
                         r, sb, eb, lb, esb, eeb, elb);
            end
            $display("random[%0d]: default soma=%0d lat=%0d; limited soma=%0d exc=%b lat=%0d",
                     r, sa, la, sb, eb, lb);
        end
    endtask

    task automatic test_reset_mid();
        int la, lb, bc, es, el;
        bit ee;
        logic [SW-1:0] sa, sb;
        logic ea, eb;
        fill_rand(255);
        do_start();
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({busy_a, done_a, soma_a, exc_a} !== '0 || {busy_b, done_b, soma_b, exc_b} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid: busy=%b done=%b soma=%0d exc=%b, required all 0",
                     busy_a, done_a, soma_a, exc_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fill_rand(200);
        ref_sum(img, 32767, es, ee, el);
        do_start();
        run_until_done(-1, la, lb, bc, sa, ea, sb, eb);
        compared++;
        if (sa !== SW'(es) || la != el || ea !== ee) begin
            mismatched++;
            $display("FAIL after_reset: soma=%0d lat=%0d exc=%b, required %0d/%0d/%b", sa, la, ea, es, el, ee);
        end
        $display("reset_mid: post-reset soma=%0d lat=%0d (expected %0d)", sa, la, es);
    endtask

    initial begin
        fill_const(0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_zero();
        test_all_max();
        test_back_to_back();
        test_abort();
        test_snapshot();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/soma_diferenca.md
Name: soma_diferenca

Overview:
Serial accumulator placed directly downstream of a per-digit DiferencaN stage. On `start` it snapshots the 11x11 array of per-pixel differences and sums them one pixel per clock in raster order. It reports the total as the template-match score for that digit, so lower means a better match. Optional early abort when the running sum exceeds LIMIT, so clearly losing digits stop early.

Parameters:
N, 11, grid side; the array is N x N pixels
W, 8, width of each diff_pixel element
SUM_W, 15, accumulator width; must satisfy 2**SUM_W > N*N*(2**W-1) (30855 < 32768)
LIMIT, 32767, early-abort threshold; with the default, abort never triggers

Ports:
clk  in  1  single system clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a new sum; sampled only in IDLE or FIM
diff_pixel  in  [N-1:0][N-1:0] x W  per-pixel differences, unpacked 2-D array
busy  out  1  accumulation in progress
done  out  1  one-cycle pulse when soma/excedeu are final
soma  out  SUM_W  final sum; held until the next accepted start
excedeu  out  1  final sum exceeded LIMIT (aborted); held with soma

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, soma=0, excedeu=0, row=col=0, accumulator=0, snapshot cleared.
- States: IDLE, ACC, FIM.
- IDLE/FIM with start=1 at edge T0:
  - capture all N*N diff_pixel into the snapshot register
  - acc=0, row=col=0, busy=1, excedeu=0, state=ACC
- ACC, every edge:
  - acc_next = acc + snap[row][col], zero-extended to SUM_W
  - advance col; on col==N-1, set col=0 and row++
  - Order: [0][0],[0][1]..[0][N-1],[1][0]..[N-1][N-1].
- Normal end: the edge adding [N-1][N-1] (T121 for N=11) does all of:
  - soma=acc_next, done=1, busy=0, state=FIM
  - Result is visible in the cycle after T121.
- Early abort: on any ACC edge where acc_next > LIMIT (strict), instead do:
  - soma=acc_next, excedeu=1, done=1, busy=0, state=FIM
  - Remaining pixels are skipped.
- FIM: done is high for exactly that one cycle. At the next edge:
  - if start=1, same as the T0 capture (back-to-back, no gap cycle)
  - else state=IDLE, done=0
- start while in ACC is ignored: no restart, no queueing.
- diff_pixel may change freely after T0; only the snapshot is used.
- soma and excedeu are updated only at completion and never show partial sums.
- The default SUM_W cannot overflow; no saturation logic is needed.
- Reset asserted mid-ACC aborts immediately to reset values; no done pulse.
- Latency: start edge to done visible = N*N edges (121) for a full sum, k edges if the abort fires on pixel k.

Decomposition:
- Shared package `reconhecimento_pkg`:
  - constants N, W, SUM_W
  - state enum {IDLE, ACC, FIM}
  - typedef for the N x N x W pixel array
- Sub-module `seletor_pixel` (combinational N*N:1 mux indexed by row/col) is natural. The FSM, counters and accumulator stay in the top module.

Test Plan:
- All diff_pixel=0, start pulse -> done at edge 121 after start; soma=0, excedeu=0; busy high for 121 cycles.
- All diff_pixel=255 -> soma=30855, excedeu=0; no overflow.
- Only [10][10]=200, rest 0 -> soma=200. Then only [0][0]=7 with back-to-back start in the FIM cycle -> soma=7, second done 121 edges later.
- LIMIT=1000, all pixels=100 -> abort at pixel 11 (sum 1100 > 1000); done 11 edges after start, soma=1100, excedeu=1.
- Change diff_pixel to 255 one cycle after start, with 1 at start -> soma=121; start pulsed mid-ACC -> ignored, single done.
- rst_n low at cycle 50 of ACC -> busy/done/soma/excedeu=0 asynchronously; a new start yields a correct full sum.
